// File: rtl/cpu_pkg.sv
// Shared opcodes, instruction field positions and ALU select encoding for the cpu slice.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;
  localparam logic [7:0] OP_MULT  = 8'h0C;

  localparam int OP_LSB   = 24;
  localparam int DST_LSB  = 16;
  localparam int SRC1_LSB = 8;
  localparam int IMM_LSB  = 0;
  localparam int REG_AW   = 3;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_MUL  = 3'd5
  } alu_sel_t;

  // Signed word count to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [7:0] words);
    return {{22{words[7]}}, words, 2'b00};
  endfunction

endpackage

// File: rtl/cpu_reg_file.sv
// Eight 8-bit registers: two combinational read ports, one write port, synchronous active-low clear.
module cpu_reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [7:0]        rdata_a,
  output logic [7:0]        rdata_b
);

  logic [7:0] regs_r [8];

  // Register write and clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_r[i] <= 8'h00;
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_r[raddr_a];
  assign rdata_b = regs_r[raddr_b];

endmodule

// File: rtl/cpu.sv
// Single-cycle 8-bit cpu top: decode, ALU, PC logic and data memory.
// Optional opcode 0x0C (mult) is enabled by defining CPU_MULT_EN.
module cpu
  import cpu_pkg::*;
#(
  parameter int DMEM_DEPTH = 256,
  parameter int PC_STEP    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC,
  input  logic [31:0] INSTRUCTION
);

  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  logic [31:0]        pc_r;
  logic [7:0]         mem_r [DMEM_DEPTH];
  logic [7:0]         op_s, off_s, imm_s;
  logic [REG_AW-1:0]  dst_s, src1_s, src2_s;
  logic [7:0]         rdata_a_s, rdata_b_s, alu_b_s, alu_res_s, wdata_s, mem_rdata_s;
  logic [DMEM_AW-1:0] mem_addr_s;
  logic [31:0]        next_pc_s;
  alu_sel_t           alu_sel_s;
  logic               use_imm_s, addr_imm_s, rf_we_s, wb_mem_s, mem_we_s, branch_s;
  logic               unused_s;

  assign op_s     = INSTRUCTION[OP_LSB +: 8];
  assign off_s    = INSTRUCTION[DST_LSB +: 8];
  assign dst_s    = INSTRUCTION[DST_LSB +: REG_AW];
  assign src1_s   = INSTRUCTION[SRC1_LSB +: REG_AW];
  assign src2_s   = INSTRUCTION[IMM_LSB +: REG_AW];
  assign imm_s    = INSTRUCTION[IMM_LSB +: 8];
  assign unused_s = ^INSTRUCTION[15:11];

  cpu_reg_file u_reg_file (
    .clk     (CLK),
    .rst_n   (RESET),
    .we      (rf_we_s),
    .waddr   (dst_s),
    .wdata   (wdata_s),
    .raddr_a (src1_s),
    .raddr_b (src2_s),
    .rdata_a (rdata_a_s),
    .rdata_b (rdata_b_s)
  );

  // Instruction decode.
  always_comb begin
    alu_sel_s  = ALU_PASS;
    use_imm_s  = 1'b0;
    addr_imm_s = 1'b0;
    rf_we_s    = 1'b0;
    wb_mem_s   = 1'b0;
    mem_we_s   = 1'b0;
    branch_s   = 1'b0;
    case (op_s)
      OP_LOADI: begin rf_we_s = 1'b1; use_imm_s = 1'b1; end
      OP_MOV:   rf_we_s = 1'b1;
      OP_ADD:   begin rf_we_s = 1'b1; alu_sel_s = ALU_ADD; end
      OP_SUB:   begin rf_we_s = 1'b1; alu_sel_s = ALU_SUB; end
      OP_AND:   begin rf_we_s = 1'b1; alu_sel_s = ALU_AND; end
      OP_OR:    begin rf_we_s = 1'b1; alu_sel_s = ALU_OR; end
      OP_J:     branch_s = 1'b1;
      OP_BEQ:   branch_s = (rdata_a_s == rdata_b_s);
      OP_LWD:   begin rf_we_s = 1'b1; wb_mem_s = 1'b1; end
      OP_LWI:   begin rf_we_s = 1'b1; wb_mem_s = 1'b1; addr_imm_s = 1'b1; end
      OP_SWD:   mem_we_s = 1'b1;
      OP_SWI:   begin mem_we_s = 1'b1; addr_imm_s = 1'b1; end
`ifdef CPU_MULT_EN
      OP_MULT:  begin rf_we_s = 1'b1; alu_sel_s = ALU_MUL; end
`endif
      default:  rf_we_s = 1'b0;
    endcase
  end

  // ALU, memory read and PC datapath.
  always_comb begin
    if (use_imm_s) alu_b_s = imm_s;
    else           alu_b_s = rdata_b_s;
    case (alu_sel_s)
      ALU_PASS: alu_res_s = alu_b_s;
      ALU_ADD:  alu_res_s = rdata_a_s + alu_b_s;
      ALU_SUB:  alu_res_s = rdata_a_s - alu_b_s;
      ALU_AND:  alu_res_s = rdata_a_s & alu_b_s;
      ALU_OR:   alu_res_s = rdata_a_s | alu_b_s;
      ALU_MUL:  alu_res_s = rdata_a_s * alu_b_s;
      default:  alu_res_s = alu_b_s;
    endcase
    if (addr_imm_s) mem_addr_s = imm_s[DMEM_AW-1:0];
    else            mem_addr_s = rdata_b_s[DMEM_AW-1:0];
    mem_rdata_s = mem_r[mem_addr_s];
    if (wb_mem_s) wdata_s = mem_rdata_s;
    else          wdata_s = alu_res_s;
    if (branch_s) next_pc_s = pc_r + 32'(PC_STEP) + branch_offset(off_s);
    else          next_pc_s = pc_r + 32'(PC_STEP);
  end

  // Program counter.
  always_ff @(posedge CLK) begin
    if (!RESET) pc_r <= 32'h0000_0000;
    else        pc_r <= next_pc_s;
  end

  // Data memory write and clear.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < DMEM_DEPTH; i++) mem_r[i] <= 8'h00;
    end else if (mem_we_s) begin
      mem_r[mem_addr_s] <= rdata_a_s;
    end
  end

  assign PC = pc_r;

endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for cpu; expected values are hand-computed from the instruction set.
module tb_cpu;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION = 32'hFF00_0000;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  cpu dut (.CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION));

  always #5 CLK = ~CLK;

  task automatic step(input logic [31:0] instr);
    INSTRUCTION = instr;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    step(32'h0004_0007);
    step(32'h0B00_0400);
    total_cnt++; if (PC !== 32'd0) $display("FAIL reset_pc got %0d want 0", PC); else pass_cnt++;
    total_cnt++; if (dut.u_reg_file.regs_r[4] !== 8'h00) $display("FAIL reset_r4 got %0h want 0", dut.u_reg_file.regs_r[4]); else pass_cnt++;
    total_cnt++; if (dut.mem_r[0] !== 8'h00) $display("FAIL reset_mem0 got %0h want 0", dut.mem_r[0]); else pass_cnt++;
    RESET = 1'b1;
  endtask

  task automatic test_program();
    step(32'h0004_0005);
    total_cnt++; if (PC !== 32'd4 || dut.u_reg_file.regs_r[4] !== 8'd5) $display("FAIL loadi_r4 pc %0d r4 %0d want 4 5", PC, dut.u_reg_file.regs_r[4]); else pass_cnt++;
    step(32'h0005_0003);
    total_cnt++; if (PC !== 32'd8 || dut.u_reg_file.regs_r[5] !== 8'd3) $display("FAIL loadi_r5 pc %0d r5 %0d want 8 3", PC, dut.u_reg_file.regs_r[5]); else pass_cnt++;
    step(32'h0003_0001);
    total_cnt++; if (PC !== 32'd12 || dut.u_reg_file.regs_r[3] !== 8'd1) $display("FAIL loadi_r3 pc %0d r3 %0d want 12 1", PC, dut.u_reg_file.regs_r[3]); else pass_cnt++;
    step(32'h0B00_0400);
    total_cnt++; if (dut.mem_r[0] !== 8'd5) $display("FAIL swi got %0d want 5", dut.mem_r[0]); else pass_cnt++;
    step(32'h0A00_0503);
    total_cnt++; if (dut.mem_r[1] !== 8'd3) $display("FAIL swd got %0d want 3", dut.mem_r[1]); else pass_cnt++;
    step(32'h0204_0405);
    total_cnt++; if (dut.u_reg_file.regs_r[4] !== 8'd8) $display("FAIL add got %0d want 8", dut.u_reg_file.regs_r[4]); else pass_cnt++;
    step(32'h0305_0405);
    total_cnt++; if (dut.u_reg_file.regs_r[5] !== 8'd5) $display("FAIL sub_raw got %0d want 5", dut.u_reg_file.regs_r[5]); else pass_cnt++;
    step(32'h0906_0000);
    total_cnt++; if (dut.u_reg_file.regs_r[6] !== 8'd5) $display("FAIL lwi got %0d want 5", dut.u_reg_file.regs_r[6]); else pass_cnt++;
    step(32'h0807_0003);
    total_cnt++; if (dut.u_reg_file.regs_r[7] !== 8'd3) $display("FAIL lwd got %0d want 3", dut.u_reg_file.regs_r[7]); else pass_cnt++;
    total_cnt++; if (PC !== 32'd36) $display("FAIL pc_after_nine got %0d want 36", PC); else pass_cnt++;
  endtask

  task automatic test_branch();
    step(32'hFF00_0000);
    total_cnt++; if (PC !== 32'd40) $display("FAIL nop_pc got %0d want 40", PC); else pass_cnt++;
    step(32'h07FE_0605);
    total_cnt++; if (PC !== 32'd36) $display("FAIL beq_taken got %0d want 36", PC); else pass_cnt++;
    step(32'hFF00_0000);
    step(32'h07FE_0405);
    total_cnt++; if (PC !== 32'd44) $display("FAIL beq_not_taken got %0d want 44", PC); else pass_cnt++;
    step(32'h0601_0000);
    total_cnt++; if (PC !== 32'd52) $display("FAIL j_fwd got %0d want 52", PC); else pass_cnt++;
  endtask

  task automatic test_logic();
    step(32'h0502_0403);
    total_cnt++; if (dut.u_reg_file.regs_r[2] !== 8'd9) $display("FAIL or got %0d want 9", dut.u_reg_file.regs_r[2]); else pass_cnt++;
    step(32'h0401_0204);
    total_cnt++; if (dut.u_reg_file.regs_r[1] !== 8'd8) $display("FAIL and got %0d want 8", dut.u_reg_file.regs_r[1]); else pass_cnt++;
    step(32'h0100_0002);
    total_cnt++; if (dut.u_reg_file.regs_r[0] !== 8'd9) $display("FAIL mov_r0 got %0d want 9", dut.u_reg_file.regs_r[0]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    step(32'h0B00_0210);
    step(32'h0907_0010);
    total_cnt++; if (dut.u_reg_file.regs_r[7] !== 8'd9) $display("FAIL store_load got %0d want 9", dut.u_reg_file.regs_r[7]); else pass_cnt++;
  endtask

  task automatic test_wrap();
    step(32'h0001_00FF);
    step(32'h0000_0001);
    step(32'h0201_0100);
    total_cnt++; if (dut.u_reg_file.regs_r[1] !== 8'h00) $display("FAIL add_wrap got %0h want 0", dut.u_reg_file.regs_r[1]); else pass_cnt++;
    step(32'h0302_0100);
    total_cnt++; if (dut.u_reg_file.regs_r[2] !== 8'hFF) $display("FAIL sub_wrap got %0h want ff", dut.u_reg_file.regs_r[2]); else pass_cnt++;
  endtask

  task automatic test_opt_mult();
    step(32'h0001_0010);
    step(32'h0002_0011);
    step(32'h0003_0000);
    step(32'h0C03_0102);
`ifdef CPU_MULT_EN
    total_cnt++; if (dut.u_reg_file.regs_r[3] !== 8'h10) $display("FAIL mult got %0h want 10", dut.u_reg_file.regs_r[3]); else pass_cnt++;
`else
    total_cnt++; if (dut.u_reg_file.regs_r[3] !== 8'h00) $display("FAIL op0c_nop got %0h want 0", dut.u_reg_file.regs_r[3]); else pass_cnt++;
`endif
  endtask

  task automatic test_mid_reset();
    RESET = 1'b0;
    step(32'hFF00_0000);
    RESET = 1'b1;
    step(32'h0004_0007);
    for (int i = 0; i < 4; i++) step(32'hFF00_0000);
    total_cnt++; if (PC !== 32'd20 || dut.u_reg_file.regs_r[4] !== 8'd7) $display("FAIL pre_reset pc %0d r4 %0d want 20 7", PC, dut.u_reg_file.regs_r[4]); else pass_cnt++;
    RESET = 1'b0;
    step(32'h0004_0009);
    total_cnt++; if (PC !== 32'd0 || dut.u_reg_file.regs_r[4] !== 8'd0) $display("FAIL mid_reset pc %0d r4 %0d want 0 0", PC, dut.u_reg_file.regs_r[4]); else pass_cnt++;
    step(32'h0602_0000);
    total_cnt++; if (PC !== 32'd0) $display("FAIL reset_over_branch got %0d want 0", PC); else pass_cnt++;
    RESET = 1'b1;
  endtask

  task automatic test_pc_wrap();
    step(32'h0680_0000);
    total_cnt++; if (PC !== 32'hFFFF_FE04) $display("FAIL pc_wrap got %0h want fffffe04", PC); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_program();
    test_branch();
    test_logic();
    test_back_to_back();
    test_wrap();
    test_opt_mult();
    test_mid_reset();
    test_pc_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
